// File: rtl/mem_split.sv
// Response splitter: routes each merged memory response beat to the output port named by its id.
// Every port has its own FIFO, so a stalled port only blocks the input once its FIFO is full.
module mem_split #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned PORTS      = 2,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  // merged response stream
  input  logic                             mem_in_valid,
  output logic                             mem_in_ready,
  input  logic [DATA_WIDTH-1:0]            mem_in_data,
  input  logic [ID_WIDTH-1:0]              mem_in_id,
  input  logic                             mem_in_read_enable,
  input  logic [MASK_WIDTH-1:0]            mem_in_write_enable,
  input  logic [ADDR_WIDTH-1:0]            mem_in_addr,
  // per-port response streams, port k in slice k
  output logic [PORTS-1:0]                 mem_out_valid,
  input  logic [PORTS-1:0]                 mem_out_ready,
  output logic [PORTS*DATA_WIDTH-1:0]      mem_out_data,
  output logic [PORTS*ID_WIDTH-1:0]        mem_out_id,
  output logic [PORTS-1:0]                 mem_out_read_enable,
  output logic [PORTS*MASK_WIDTH-1:0]      mem_out_write_enable,
  output logic [PORTS*ADDR_WIDTH-1:0]      mem_out_addr,
  output logic                             bad_id
);

  localparam int unsigned EntryW = 1 + MASK_WIDTH + ADDR_WIDTH + DATA_WIDTH + ID_WIDTH;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned DataLo = ID_WIDTH;
  localparam int unsigned AddrLo = DataLo + DATA_WIDTH;
  localparam int unsigned MaskLo = AddrLo + ADDR_WIDTH;
  localparam logic [CntW-1:0]     DepthC = CntW'(DEPTH);
  localparam logic [ID_WIDTH:0]   PortsC = (ID_WIDTH + 1)'(PORTS);

  if (PORTS < 2) begin : g_chk_ports
    $error("mem_split: PORTS must be greater than 1");
  end
  if (ID_WIDTH < $clog2(PORTS)) begin : g_chk_id
    $error("mem_split: ID_WIDTH too narrow for PORTS");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("mem_split: DEPTH must be a power of two and at least 2");
  end

  logic [EntryW-1:0] fifo_q   [PORTS][DEPTH];
  logic [PtrW-1:0]   wr_ptr_q [PORTS];
  logic [PtrW-1:0]   rd_ptr_q [PORTS];
  logic [CntW-1:0]   count_q  [PORTS];
  logic              bad_id_q;

  logic              routable;
  logic              tgt_full;
  logic              accept;
  logic [PORTS-1:0]  push;
  logic [PORTS-1:0]  pop;
  logic [EntryW-1:0] entry;

  assign routable = ({1'b0, mem_in_id} < PortsC);
  assign entry    = {mem_in_read_enable, mem_in_write_enable, mem_in_addr, mem_in_data, mem_in_id};

  // Ready looks only at registered counts, never at any output ready.
  always_comb begin
    tgt_full = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (mem_in_id == ID_WIDTH'(k)) tgt_full = (count_q[k] == DepthC);
    end
  end

  assign mem_in_ready = !rst && (!routable || !tgt_full);
  assign accept       = mem_in_valid && mem_in_ready;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < PORTS; k++) begin
      push[k] = accept && routable && (mem_in_id == ID_WIDTH'(k));
      pop[k]  = mem_out_valid[k] && mem_out_ready[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PORTS; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      bad_id_q <= 1'b0;
    end else begin
      if (accept && !routable) bad_id_q <= 1'b1;
      for (int k = 0; k < PORTS; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        if (push[k] && !pop[k]) begin
          count_q[k] <= count_q[k] + 1'b1;
        end else if (pop[k] && !push[k]) begin
          count_q[k] <= count_q[k] - 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      if (push[k]) fifo_q[k][wr_ptr_q[k]] <= entry;
    end
  end

  for (genvar k = 0; k < PORTS; k++) begin : g_out
    logic [EntryW-1:0] head;
    assign head             = fifo_q[k][rd_ptr_q[k]];
    assign mem_out_valid[k] = (count_q[k] != '0);
    assign mem_out_id[k*ID_WIDTH +: ID_WIDTH]          = head[ID_WIDTH-1:0];
    assign mem_out_data[k*DATA_WIDTH +: DATA_WIDTH]    = head[DataLo +: DATA_WIDTH];
    assign mem_out_addr[k*ADDR_WIDTH +: ADDR_WIDTH]    = head[AddrLo +: ADDR_WIDTH];
    assign mem_out_write_enable[k*MASK_WIDTH +: MASK_WIDTH] = head[MaskLo +: MASK_WIDTH];
    assign mem_out_read_enable[k] = head[EntryW-1];
  end

  assign bad_id = bad_id_q;

endmodule

// File: tb/tb_mem_split.sv
// Bench for mem_split: per-port expected-response queues filled on accept, drained and compared
// by an independent monitor; directed cases followed by a randomized soak.
module tb_mem_split;

  localparam int P = 3;
  localparam int D = 4;

  typedef struct packed {
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  id;
  } beat_t;

  logic          clk, rst;
  logic          mem_in_valid, mem_in_ready;
  logic [31:0]   mem_in_data, mem_in_addr;
  logic [1:0]    mem_in_id;
  logic          mem_in_read_enable;
  logic [3:0]    mem_in_write_enable;
  logic [P-1:0]  mem_out_valid, mem_out_ready, mem_out_read_enable;
  logic [P*32-1:0] mem_out_data, mem_out_addr;
  logic [P*2-1:0]  mem_out_id;
  logic [P*4-1:0]  mem_out_write_enable;
  logic          bad_id;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q [P][$];
  logic  exp_bad = 1'b0;
  bit    soak_on = 1'b0;

  mem_split #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .ID_WIDTH(2), .PORTS(P), .DEPTH(D)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_in_valid         (mem_in_valid),
    .mem_in_ready         (mem_in_ready),
    .mem_in_data          (mem_in_data),
    .mem_in_id            (mem_in_id),
    .mem_in_read_enable   (mem_in_read_enable),
    .mem_in_write_enable  (mem_in_write_enable),
    .mem_in_addr          (mem_in_addr),
    .mem_out_valid        (mem_out_valid),
    .mem_out_ready        (mem_out_ready),
    .mem_out_data         (mem_out_data),
    .mem_out_id           (mem_out_id),
    .mem_out_read_enable  (mem_out_read_enable),
    .mem_out_write_enable (mem_out_write_enable),
    .mem_out_addr         (mem_out_addr),
    .bad_id               (bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT against the reference queues, away from the active edge.
  always @(negedge clk) begin : monitor
    beat_t act;
    logic  er;
    if (rst) begin
      chk("rst_ready", mem_in_ready, 0);
      chk("rst_valid", mem_out_valid, 0);
      chk("rst_bad_id", bad_id, 0);
    end else begin
      if (int'(mem_in_id) >= P) er = 1'b1;
      else er = (exp_q[mem_in_id].size() < D);
      chk("in_ready", mem_in_ready, er);
      for (int k = 0; k < P; k++) begin
        chk($sformatf("valid%0d", k), mem_out_valid[k], exp_q[k].size() != 0);
        if (mem_out_valid[k] && exp_q[k].size() != 0) begin
          act.re   = mem_out_read_enable[k];
          act.we   = mem_out_write_enable[k*4 +: 4];
          act.addr = mem_out_addr[k*32 +: 32];
          act.data = mem_out_data[k*32 +: 32];
          act.id   = mem_out_id[k*2 +: 2];
          chk($sformatf("beat%0d", k), act, exp_q[k][0]);
        end
      end
      chk("bad_id", bad_id, exp_bad);
    end
  end

  // Reference model update: a pop retires the oldest beat, an accept queues it for its port.
  always @(posedge clk) begin : model
    beat_t b;
    if (rst) begin
      for (int k = 0; k < P; k++) exp_q[k].delete();
      exp_bad = 1'b0;
    end else begin
      for (int k = 0; k < P; k++) begin
        if (mem_out_valid[k] && mem_out_ready[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
      end
      if (mem_in_valid && mem_in_ready) begin
        b = '{re: mem_in_read_enable, we: mem_in_write_enable, addr: mem_in_addr,
              data: mem_in_data, id: mem_in_id};
        if (int'(mem_in_id) < P) exp_q[mem_in_id].push_back(b);
        else exp_bad = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (soak_on) begin
      #1;
      mem_out_ready = P'($urandom);
    end
  end

  task automatic drive(input logic [1:0] id, input logic [31:0] data);
    mem_in_valid        = 1'b1;
    mem_in_id           = id;
    mem_in_data         = data;
    mem_in_addr         = $urandom;
    mem_in_write_enable = 4'($urandom);
    mem_in_read_enable  = 1'($urandom);
  endtask

  task automatic send(input logic [1:0] id, input logic [31:0] data);
    bit acc = 1'b0;
    int n = 0;
    drive(id, data);
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = mem_in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    mem_in_valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL send_timeout: id %0d not accepted after %0d cycles", id, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    mem_out_ready = '1;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (n >= 500) begin
      miscompares++;
      $display("FAIL drain_timeout: entries still pending after %0d cycles", n);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_out_ready = '1;
    drive(2'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic routing, back-to-back.
    send(2'd0, 32'hA0);
    send(2'd1, 32'hB1);
    drain();

    // Backpressure: fill port 0, the next beat must wait until one entry has been popped.
    mem_out_ready = 3'b110;
    for (int i = 0; i < D; i++) send(2'd0, 32'h100 + i);
    drive(2'd0, 32'h100 + D);
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", mem_in_ready, 0);
    end
    @(posedge clk);
    #1;
    mem_out_ready = '1;
    @(negedge clk);
    chk("full_with_pop", mem_in_ready, 0);
    @(negedge clk);
    chk("ready_after_pop", mem_in_ready, 1);
    @(posedge clk);
    #1;
    mem_in_valid = 1'b0;
    drain();

    // Independence: head beat for full port 0 blocks a following id-1 beat.
    mem_out_ready = 3'b110;
    for (int i = 0; i < D; i++) send(2'd0, 32'h200 + i);
    drive(2'd0, 32'h2FF);
    repeat (3) begin
      @(negedge clk);
      chk("blocked_ready", mem_in_ready, 0);
      chk("port1_idle", mem_out_valid[1], 0);
    end
    @(posedge clk);
    #1;
    mem_out_ready = '1;
    send(2'd0, 32'h2FF);
    send(2'd1, 32'hB2);
    drain();

    // Bad id: dropped, sticky flag.
    send(2'd3, 32'hDEAD);
    repeat (4) begin
      @(negedge clk);
      chk("bad_id_sticky", bad_id, 1);
      chk("bad_no_valid", mem_out_valid, 0);
    end

    // Async reset mid-operation discards buffered beats.
    mem_out_ready = '0;
    send(2'd0, 32'h300);
    send(2'd1, 32'h301);
    send(2'd2, 32'h302);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", mem_out_valid, 0);
    chk("async_bad_id", bad_id, 0);
    chk("async_ready", mem_in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_out_ready = '1;
    @(posedge clk);
    #1;

    // Random soak.
    soak_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom), $urandom);
    end
    soak_on = 1'b0;
    @(posedge clk);
    #2;
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
